// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule expander.
// Holds the word type, block geometry, default round count and FSM states.
package sha256_pkg;

    localparam int BLOCK_W        = 512;
    localparam int ROUNDS_DEFAULT = 64;
    localparam int WIN_DEPTH      = 16;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Big-endian word extraction: word 0 is the most significant 32 bits.
    function automatic word_t block_word(input logic [BLOCK_W-1:0] blk, input int idx);
        return blk[BLOCK_W-1-idx*32 -: 32];
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small-sigma: rotr(x,R1) ^ rotr(x,R2) ^ shr(x,S), purely combinational.
// (7,18,3) gives sigma0 and (17,19,10) gives sigma1.
module sha256_small_sigma #(
    parameter int R1 = 7,
    parameter int R2 = 18,
    parameter int S  = 3
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] rot1;
    logic [31:0] rot2;
    logic [31:0] shr;

    assign rot1 = (x >> R1) | (x << (32 - R1));
    assign rot2 = (x >> R2) | (x << (32 - R2));
    assign shr  = x >> S;
    assign y    = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_sched.sv
// Sequential SHA-256 message-schedule expander: loads one 512-bit block, streams W[0..ROUNDS-1].
// Optional macro SHA256_SCHED_PREFETCH_EN allows zero-bubble back-to-back blocks.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [5:0]         w_index,
    output logic               w_last,
    output state_t             state_dbg
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] win [WIN_DEPTH];
    logic [5:0]        t;
    logic              at_last;
    logic              w_fire;
    logic              blk_fire;
    logic              load;
    logic              shift;
    logic              clear_t;
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] new_word;

    sha256_small_sigma #(.R1(7),  .R2(18), .S(3))  u_sigma0 (.x(win[1]),  .y(s0));
    sha256_small_sigma #(.R1(17), .R2(19), .S(10)) u_sigma1 (.x(win[14]), .y(s1));

    assign new_word = s1 + win[9] + s0 + win[0];

    // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
    // source holds its payload stable until that edge, and ready may depend on state.
    assign at_last   = (t == LAST_T);
    assign w_valid   = (state == STREAM);
    assign w_data    = win[0];
    assign w_index   = t;
    assign w_last    = (state == STREAM) && at_last;
    assign state_dbg = state;
`ifdef SHA256_SCHED_PREFETCH_EN
    // Ready for the next block only when this cycle's final word is being taken.
    assign blk_ready = (state == IDLE) || ((state == STREAM) && at_last && w_ready);
`else
    assign blk_ready = (state == IDLE);
`endif
    assign w_fire    = w_valid && w_ready;
    assign blk_fire  = blk_valid && blk_ready;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        clear_t    = 1'b0;
        case (state)
            IDLE: begin
                if (blk_fire) begin
                    load       = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (w_fire) begin
                    if (!at_last) begin
                        shift = 1'b1;
                    end else begin
`ifdef SHA256_SCHED_PREFETCH_EN
                        if (blk_fire) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            clear_t    = 1'b1;
                        end
`else
                        state_next = IDLE;
                        clear_t    = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window always holds W[t..t+15]; the shift runs for every accepted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win[i] <= '0;
            end
            t <= '0;
        end else if (load) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win[i] <= block_word(blk_data, i);
            end
            t <= '0;
        end else if (shift) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[WIN_DEPTH-1] <= new_word;
            t                <= t + 6'd1;
        end else if (clear_t) begin
            t <= '0;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: directed blocks, scoreboard queue, decoupled monitor.
// Expected words come from hand constants and an array-form schedule recurrence.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         w_last;
    state_t       state_dbg;

    sha256_msg_sched #(.ROUNDS(ROUNDS), .WORD_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .w_last    (w_last),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [38:0] exp_q[$];   // {last, index[5:0], data[31:0]}
    int          kind = 0;   // 1: "abc" block, 2: all-ones block, 0: no spot checks
    logic        ready_rand = 1'b0;
    logic        ready_hold = 1'b1;
    logic        seen_last = 1'b0;
    int          gap_cnt = 0;
    int          last_gap = -1;

    logic [511:0] abc_blk;
    logic [511:0] ones_blk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule in the textbook array form W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [511:0] b;
        b = blk;
        for (int i = 0; i < 16; i++) begin
            w[i] = b[511-32*i -: 32];
        end
        for (int i = 16; i < 64; i++) begin
            w[i] = sig1(w[i-2]) + w[i-7] + sig0(w[i-15]) + w[i-16];
        end
        for (int i = 0; i < ROUNDS; i++) begin
            exp_q.push_back({(i == ROUNDS - 1), 6'(i), w[i]});
        end
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            w_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    task automatic send_block(input logic [511:0] blk, input logic keep);
        logic ok;
        ok = 1'b0;
        blk_valid = 1'b1;
        blk_data  = blk;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (blk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL blk_accept actual=timeout required=blk_ready");
            blk_valid = 1'b0;
        end else begin
            push_block(blk);
            @(posedge clk);
            #1;
            if (!keep) blk_valid = 1'b0;
            check("first_valid", 32'(w_valid), 32'd1);
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d_left required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_index(input int idx);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (w_valid && (32'(w_index) == idx)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_index actual=timeout required=%0d", idx);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [38:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && w_valid) begin
                if (seen_last) begin
                    last_gap  = gap_cnt;
                    seen_last = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word actual=%h@%0d required=none", w_data, w_index);
                end else begin
                    e = exp_q[0];
                    check("w_data", w_data, e[31:0]);
                    check("w_index", 32'(w_index), 32'(e[37:32]));
                    check("w_last", 32'(w_last), 32'(e[38]));
                    if (kind == 1 && w_index == 6'd0)  check("abc_w0", w_data, 32'h61626380);
                    if (kind == 1 && w_index == 6'd15) check("abc_w15", w_data, 32'h00000018);
                    if (kind == 1 && w_index == 6'd16) check("abc_w16", w_data, 32'h61626380);
                    if (kind == 1 && w_index == 6'd17) check("abc_w17", w_data, 32'h000F0000);
                    if (kind == 2 && w_index == 6'd16) check("ones_w16", w_data, 32'h203FFFFC);
                    if (w_ready) begin
                        void'(exp_q.pop_front());
                        if (w_last) begin
                            seen_last = 1'b1;
                            gap_cnt   = 0;
                        end
                    end
                end
            end else if (rst_n && seen_last) begin
                gap_cnt++;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        abc_blk  = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        ones_blk = '1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_index", 32'(w_index), 32'd0);
        check("rst_w_last", 32'(w_last), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;

        // 1: "abc" block, w_ready held high
        kind = 1;
        send_block(abc_blk, 1'b0);
        drain();
        @(posedge clk);
        #1;
        check("abc_end_blk_ready", 32'(blk_ready), 32'd1);
        check("abc_end_w_valid", 32'(w_valid), 32'd0);

        // 2: all-ones block, wrap of the four-term sum
        kind = 2;
        send_block(ones_blk, 1'b0);
        drain();

        // 3: "abc" again under random backpressure
        kind = 1;
        ready_rand = 1'b1;
        send_block(abc_blk, 1'b0);
        drain();
        ready_rand = 1'b0;
        @(posedge clk);
        #1;

        // 4: reset for one cycle at t=20, then reload
        send_block(abc_blk, 1'b0);
        wait_index(20);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        seen_last = 1'b0;
        rst_n = 1'b1;
        check("midrst_w_valid", 32'(w_valid), 32'd0);
        check("midrst_blk_ready", 32'(blk_ready), 32'd1);
        check("midrst_w_index", 32'(w_index), 32'd0);
        check("midrst_w_data", w_data, 32'd0);
        send_block(abc_blk, 1'b0);
        drain();

        // 5: two blocks with blk_valid held high
        kind = 0;
        @(posedge clk);
        #1;
        seen_last = 1'b0;
        last_gap  = -1;
        send_block(abc_blk, 1'b1);
        send_block(ones_blk, 1'b0);
        drain();
`ifdef SHA256_SCHED_PREFETCH_EN
        check("b2b_gap", 32'(last_gap), 32'd0);
`else
        check("b2b_gap", 32'(last_gap), 32'd1);
`endif

        // 6: blk_valid raised mid-stream at t=10 must not load
        kind = 1;
        @(posedge clk);
        #1;
        send_block(abc_blk, 1'b0);
        wait_index(10);
        blk_valid = 1'b1;
        blk_data  = ones_blk;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midstream_blk_ready", 32'(blk_ready), 32'd0);
        end
        blk_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        check("final_w_valid", 32'(w_valid), 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Sequential SHA-256 message-schedule expander. Accepts one 512-bit padded block and streams W[0..63] one word per handshake to the compression round core.
- Sits between the block padder/loader and the round engine.
- Small-sigma functions are computed internally, combinationally on a 16-word sliding window.

Parameters:
- ROUNDS, 64: number of W words emitted per block. Legal values are 17..64; the default is used in production.
- WORD_W, 32: word width. Fixed at 32 and never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- blk_valid  in  1  upstream block available.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  512  padded block, big-endian. Word 0 = blk_data[511:480], word 15 = blk_data[31:0].
- w_valid  out  1  w_data is valid.
- w_ready  in  1  downstream accepts the word.
- w_data  out  32  current schedule word W[t].
- w_index  out  6  t, the index of w_data.
- w_last  out  1  high with w_valid when t == ROUNDS-1.

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-low on rst_n. When rst_n is low at a rising clk edge, the block goes to state IDLE with:
  - blk_ready=1, w_valid=0, w_data=0, w_index=0, w_last=0
  - window registers cleared.
- Reset mid-stream aborts the block immediately. No further words are emitted, and the next accepted block starts at t=0.
- States:
  - IDLE:
    - blk_ready=1, w_valid=0.
    - On blk_valid && blk_ready, load win[0..15] = words 0..15, set t=0, go to STREAM.
  - STREAM:
    - w_valid=1, w_data=win[0], w_index=t, w_last=(t==ROUNDS-1).
    - On w_valid && w_ready with t<ROUNDS-1: win[i]<=win[i+1] for i=0..14, win[15]<=new, t<=t+1.
    - On w_valid && w_ready with t==ROUNDS-1: go to IDLE.
- new = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0], modulo 2^32, with carries discarded.
  - ssig0(x) = rotr7 ^ rotr18 ^ shr3.
  - ssig1(x) = rotr17 ^ rotr19 ^ shr10.
- For t<16, the emitted words are the loaded words unchanged. The shift still runs on every handshake, so the window is always aligned as W[t..t+15].
- Latency: the first w_valid is the cycle after block acceptance. After that, one word per cycle when w_ready is held high, giving 64 cycles per block.
- Backpressure: while w_valid && !w_ready, w_data, w_index, w_last and the window hold stable. w_valid never drops in STREAM until the final handshake.
- blk_ready is 0 in STREAM unless the optional feature is enabled. blk_data is sampled only on its handshake.
- w_index wraps only through reset or return to IDLE. It never exceeds ROUNDS-1.

Optional Feature:
- Macro: SHA256_SCHED_PREFETCH_EN.
- When defined:
  - blk_ready is also high in STREAM when t==ROUNDS-1.
  - If the final w handshake and the blk handshake occur in the same cycle, the new block loads, t=0, and the state stays STREAM.
  - Result: zero-bubble back-to-back blocks, 64 cycles per block.
  - If the blk handshake completes in that cycle without the w handshake: invalid. blk_ready must then be driven as ((t==ROUNDS-1) && w_ready), so this cannot occur.
- When undefined: there is at least one IDLE cycle between blocks, giving 65 cycles per block.

Decomposition:
- Package sha256_pkg holds:
  - word typedef (32-bit)
  - BLOCK_W=512
  - ROUNDS_DEFAULT=64
  - state enum {IDLE, STREAM}
- Sub-module sha256_small_sigma: combinational, parameters R1, R2, S. Output = rotr(x,R1) ^ rotr(x,R2) ^ shr(x,S). Instantiated twice: (7,18,3) and (17,19,10).

Test Plan:
1. "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1:
   - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
   - 64 words total; w_last only on index 63; blk_ready returns 1 the next cycle.
2. All-ones block: W16=0x203FFFFC, which exercises modulo-2^32 wrap of the four-term sum.
3. Random w_ready toggling on block 1: output sequence identical to run 1; w_data stable whenever w_valid && !w_ready.
4. rst_n low for one cycle at t=20:
   - Next cycle w_valid=0, blk_ready=1.
   - A reloaded "abc" block restarts at W0=0x61626380.
5. Two consecutive blocks with blk_valid held high:
   - Without the macro: one-cycle gap, w_valid=0 for exactly one cycle.
   - With SHA256_SCHED_PREFETCH_EN: index 63 is followed directly by index 0 of the second block.
6. blk_valid asserted during STREAM at t=10 (macro off): no load, blk_ready=0, stream unaffected.
